ins_cache: RTL
==============

// Module: ins_cache
// PURPOSE
//  Direct-mapped instruction cache between the fetch stage and the memory controller.
//  Serves 32-bit fetches on a hit one cycle after the request.
//  On a miss, it issues a one-word read on the memctrl icache port, fills the line and replies to fetch.
//  Lines are kept across branch flush (clear); a flush only cancels the fetch in flight.
// PARAMETERS
//  INDEX_BITS  8   line index width; 2**INDEX_BITS lines of one 32-bit word each
//  TAG_BITS    32-INDEX_BITS-2   derived (localparam), tag = pc[31:INDEX_BITS+2]
// PORTS
//  clk                  in   1   system clock, all state on posedge
//  reset                in   1   asynchronous, active-LOW reset (0 = reset)
//  ready                in   1   global enable; 0 freezes all state and outputs
//  clear                in   1   branch-mispredict flush, synchronous, high for one cycle
//  if_in_flag           in   1   fetch request; held with if_pc until if_out_flag is seen
//  if_pc                in   32  fetch address; bits [1:0] ignored
//  if_out_flag          out  1   one-cycle pulse: if_ins valid for the current request
//  if_ins               out  32  fetched instruction; holds value between pulses
//  icache_mem_in_flag   out  1   read request to memctrl, level, held until icache_mem_out_flag
//  icache_mem_pc        out  32  word-aligned miss address {if_pc[31:2],2'b00}
//  icache_mem_out_flag  in   1   memctrl one-cycle completion pulse
//  icache_mem_ins       in   32  memctrl read data, valid with icache_mem_out_flag
// BEHAVIOUR
//  Reset (reset==0, async):
//   - state=IDLE; all valid bits=0.
//   - if_out_flag=0, if_ins=0, icache_mem_in_flag=0, icache_mem_pc=0.
//   - Arrays (tag, data) are not reset.
//  Priority per edge: reset > clear > !ready (hold everything) > FSM.
//  Lookup: idx=if_pc[INDEX_BITS+1:2]; hit = valid[idx] && tag[idx]==if_pc[31:INDEX_BITS+2].
//  FSM states:
//   IDLE: if if_in_flag:
//     - hit  -> if_ins<=data[idx], if_out_flag<=1, go DONE (1-cycle latency).
//     - miss -> icache_mem_in_flag<=1, icache_mem_pc<={if_pc[31:2],2'b00}, go MISS.
//   MISS: wait for icache_mem_out_flag. Request stays asserted; address stays constant.
//     - On the pulse: write data/tag[idx], set valid[idx].
//     - Same edge: if_ins<=icache_mem_ins, if_out_flag<=1, icache_mem_in_flag<=0, go DONE.
//   DONE: if_out_flag<=0, requests ignored this cycle, go IDLE.
//     - This covers the requester's one-cycle reaction lag and prevents double responses.
//     - It also spans memctrl's post-completion stall, so no spurious re-request is issued.
//  Responses:
//   - if_out_flag is high exactly one cycle per served request; it is 0 in every other cycle.
//   - Miss latency equals memctrl latency plus 1 edge; no new request is issued while one is pending.
//  clear:
//   - state<=IDLE, if_out_flag<=0, icache_mem_in_flag<=0; valid bits retained.
//   - If icache_mem_out_flag is high in the clear cycle, the line is still filled.
//     No fetch response is given.
//  ready==0: FSM, flags and arrays hold; pending mem request stays asserted.
//  Single write port (fill only), combinational read; no self-modifying-code coherence
//   (stores do not invalidate lines).
// TESTING
//  1. Reset, fetch pc=0x0 -> mem_in_flag=1, mem_pc=0x0.
//     Return 0x00000013 -> if_out_flag 1 cycle, if_ins=0x13.
//     Refetch 0x0 -> hit, pulse next cycle, no mem request.
//  2. Conflict: fetch 0x0, then 0x400 (same idx, INDEX_BITS=8).
//     -> 0x400 misses and evicts; refetch 0x0 misses again.
//  3. Fetch 0x6 -> mem_pc=0x4.
//     Fetch 0x4 afterwards -> hit with the same data.
//  4. clear during MISS -> mem_in_flag=0 next edge, no if_out_flag.
//     Same pc refetched -> new miss request.
//  5. ready=0 for 3 cycles in IDLE with a hit request.
//     -> no pulse while low; pulse one cycle after ready returns.
//  6. Drive reset low mid-MISS -> all outputs 0 immediately.
//     Previously hit pc=0x0 now misses.

Source files
------------

// File: rtl/ins_cache_if.sv
// Fetch-side and memctrl-side signal bundle for the instruction cache.
//   slave  : the cache. It receives fetch requests and memctrl completions,
//            and drives fetch responses and memctrl read requests.
//   master : the environment (fetch stage + memctrl) facing the cache.
interface ins_cache_if;
  logic        if_in_flag;
  logic [31:0] if_pc;
  logic        if_out_flag;
  logic [31:0] if_ins;
  logic        icache_mem_in_flag;
  logic [31:0] icache_mem_pc;
  logic        icache_mem_out_flag;
  logic [31:0] icache_mem_ins;

  modport slave (
    input  if_in_flag, if_pc, icache_mem_out_flag, icache_mem_ins,
    output if_out_flag, if_ins, icache_mem_in_flag, icache_mem_pc
  );

  modport master (
    output if_in_flag, if_pc, icache_mem_out_flag, icache_mem_ins,
    input  if_out_flag, if_ins, icache_mem_in_flag, icache_mem_pc
  );
endinterface

// File: rtl/ins_cache.sv
// Direct-mapped instruction cache, one 32-bit word per line.
// A hit is answered one edge after the request. A miss issues a one-word read to
// memctrl, fills the line and answers fetch on the completion edge.
// Ports:
//   clk    : clock, all state on posedge
//   reset  : asynchronous active-low reset
//   ready  : global enable; 0 holds all state and outputs
//   clear  : branch flush; cancels the fetch in flight, keeps cached lines
//   bus    : ins_cache_if.slave (fetch request/response, memctrl read port)
module ins_cache #(
  parameter int INDEX_BITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ready,
  input  logic        clear,
  ins_cache_if.slave  bus
);
  localparam int TAG_BITS = 32 - INDEX_BITS - 2;
  localparam int LINES    = 1 << INDEX_BITS;

  typedef enum logic [1:0] {IDLE, MISS, DONE} state_e;

  state_e             state_q, state_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic               out_flag_q, out_flag_d;
  logic [31:0]        ins_q, ins_d;
  logic               mem_req_q, mem_req_d;
  logic [31:0]        mem_pc_q, mem_pc_d;

  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [31:0]         data_mem [LINES];

  logic [INDEX_BITS-1:0] idx, fill_idx;
  logic [TAG_BITS-1:0]   tag, fill_tag;
  logic                  hit, fill_en;

  assign idx = bus.if_pc[INDEX_BITS+1:2];
  assign tag = bus.if_pc[31:INDEX_BITS+2];
  assign hit = valid_q[idx] && (tag_mem[idx] == tag);

  // Fill from the latched miss address, not if_pc: after a flush the fetch
  // address may already have moved on while memctrl is still completing.
  assign fill_idx = mem_pc_q[INDEX_BITS+1:2];
  assign fill_tag = mem_pc_q[31:INDEX_BITS+2];
  // A completion landing in the flush cycle still fills the line.
  assign fill_en  = (state_q == MISS) && bus.icache_mem_out_flag && (clear || ready);

  always_comb begin
    valid_d = valid_q;
    if (fill_en) valid_d[fill_idx] = 1'b1;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else if (ready) begin
      case (state_q)
        IDLE:    if (bus.if_in_flag) state_d = hit ? DONE : MISS;
        MISS:    if (bus.icache_mem_out_flag) state_d = DONE;
        DONE:    state_d = IDLE; // absorbs requester lag and memctrl stall
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic (next values of the registered outputs)
  always_comb begin
    out_flag_d = out_flag_q;
    ins_d      = ins_q;
    mem_req_d  = mem_req_q;
    mem_pc_d   = mem_pc_q;
    if (clear) begin
      out_flag_d = 1'b0;
      mem_req_d  = 1'b0;
    end else if (ready) begin
      out_flag_d = 1'b0; // response is a single-cycle pulse
      case (state_q)
        IDLE: if (bus.if_in_flag) begin
          if (hit) begin
            ins_d      = data_mem[idx];
            out_flag_d = 1'b1;
          end else begin
            mem_req_d = 1'b1;
            mem_pc_d  = {bus.if_pc[31:2], 2'b00};
          end
        end
        MISS: if (bus.icache_mem_out_flag) begin
          ins_d      = bus.icache_mem_ins;
          out_flag_d = 1'b1;
          mem_req_d  = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q    <= '0;
      out_flag_q <= 1'b0;
      ins_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_pc_q   <= '0;
    end else begin
      valid_q    <= valid_d;
      out_flag_q <= out_flag_d;
      ins_q      <= ins_d;
      mem_req_q  <= mem_req_d;
      mem_pc_q   <= mem_pc_d;
    end
  end

  // Tag/data arrays are never reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= bus.icache_mem_ins;
    end
  end

  assign bus.if_out_flag        = out_flag_q;
  assign bus.if_ins             = ins_q;
  assign bus.icache_mem_in_flag = mem_req_q;
  assign bus.icache_mem_pc      = mem_pc_q;
endmodule
